// File: rtl/bank_load_sequencer.sv
// bank_load_sequencer: accepts one host command and then drives the register-bank
// datapath. It issues one load strobe per enabled register in the order
// V1, V2, R, IR1, IR2, waits the programmed number of execution cycles, and
// captures the datapath display output as the result.
//
// Handshake: a command transfers on a rising edge where start_valid=1 and
// start_ready=1. start_ready is high only in IDLE. start_valid seen while busy
// is dropped rather than queued. The host does not have to hold start_valid
// once the command has been accepted.
module bank_load_sequencer #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [4:0]    load_mask,
  input  logic [W-1:0]  v1_val,
  input  logic [W-1:0]  v2_val,
  input  logic [W-1:0]  r_val,
  input  logic [W-1:0]  ir1_val,
  input  logic [W-1:0]  ir2_val,
  input  logic [CW-1:0] exec_cycles,
  input  logic          abort,
  input  logic [W-1:0]  display_in,
  output logic [W-1:0]  value,
  output logic          ldV1,
  output logic          ldV2,
  output logic          ldR,
  output logic          ldIR1,
  output logic          ldIR2,
  output logic          busy,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic [1:0]    stateDbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    EXEC    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [4:0]    maskQ;
  logic [W-1:0]  v1Q, v2Q, rQ, ir1Q, ir2Q;
  logic [CW-1:0] cntQ;

  // Lowest pending register: isolate the lowest set bit of the remaining mask.
  logic [4:0] lowBit;
  logic       lastLoad;
  assign lowBit   = maskQ & (~maskQ + 5'd1);
  assign lastLoad = ((maskQ & ~lowBit) == 5'd0);

  logic accept;
  assign accept = (state == IDLE) && start_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start_valid) stateNext = (load_mask != 5'd0) ? LOAD : EXEC;
      end
      LOAD: begin
        if (abort)         stateNext = IDLE;
        else if (lastLoad) stateNext = EXEC;
      end
      EXEC: begin
        if (abort)                  stateNext = IDLE;
        else if (cntQ == '0)        stateNext = CAPTURE;
      end
      CAPTURE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Command latches, load mask consumption, execution counter
  always_ff @(posedge clk) begin
    if (rst) begin
      maskQ <= '0;
      v1Q   <= '0;
      v2Q   <= '0;
      rQ    <= '0;
      ir1Q  <= '0;
      ir2Q  <= '0;
      cntQ  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            maskQ <= load_mask;
            v1Q   <= v1_val;
            v2Q   <= v2_val;
            rQ    <= r_val;
            ir1Q  <= ir1_val;
            ir2Q  <= ir2_val;
            cntQ  <= exec_cycles;
          end
        end
        LOAD: maskQ <= maskQ & ~lowBit;
        EXEC: if (cntQ != '0) cntQ <= cntQ - 1'b1;
        default: ;
      endcase
    end
  end

  // Result capture and one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == CAPTURE);
      if (state == CAPTURE) result <= display_in;
    end
  end

  // Moore outputs: strobe and bus word selected by the lowest pending bit
  always_comb begin
    ldV1  = 1'b0;
    ldV2  = 1'b0;
    ldR   = 1'b0;
    ldIR1 = 1'b0;
    ldIR2 = 1'b0;
    value = '0;
    if (state == LOAD) begin
      case (lowBit)
        5'b00001: begin ldV1  = 1'b1; value = v1Q;  end
        5'b00010: begin ldV2  = 1'b1; value = v2Q;  end
        5'b00100: begin ldR   = 1'b1; value = rQ;   end
        5'b01000: begin ldIR1 = 1'b1; value = ir1Q; end
        5'b10000: begin ldIR2 = 1'b1; value = ir2Q; end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign start_ready = (state == IDLE);
  assign stateDbg    = state;

endmodule

// File: tb/tb_bank_load_sequencer.sv
// tb_bank_load_sequencer: directed bench for bank_load_sequencer.
// Each run of runOp walks one command cycle by cycle. Hand-picked words,
// masks and exec counts set the expected strobe order, the bus value and the
// result timing.
module tb_bank_load_sequencer;
  localparam int W  = 16;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [4:0]    load_mask;
  logic [W-1:0]  v1_val, v2_val, r_val, ir1_val, ir2_val;
  logic [CW-1:0] exec_cycles;
  logic          abort;
  logic [W-1:0]  display_in;
  logic [W-1:0]  value;
  logic          ldV1, ldV2, ldR, ldIR1, ldIR2;
  logic          busy;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [1:0]    stateDbg;

  logic [4:0] strobeVec;
  assign strobeVec = {ldIR2, ldIR1, ldR, ldV2, ldV1};

  bank_load_sequencer #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .load_mask(load_mask),
    .v1_val(v1_val), .v2_val(v2_val), .r_val(r_val),
    .ir1_val(ir1_val), .ir2_val(ir2_val),
    .exec_cycles(exec_cycles), .abort(abort), .display_in(display_in),
    .value(value),
    .ldV1(ldV1), .ldV2(ldV2), .ldR(ldR), .ldIR1(ldIR1), .ldIR2(ldIR2),
    .busy(busy), .result(result), .result_valid(result_valid),
    .stateDbg(stateDbg)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] lastResult;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveCmd(input logic [4:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] e,
                          input logic [CW-1:0] ex, input logic [W-1:0] disp);
    load_mask   = mask;
    v1_val      = a;
    v2_val      = b;
    r_val       = c;
    ir1_val     = d;
    ir2_val     = e;
    exec_cycles = ex;
    display_in  = disp;
    start_valid = 1'b1;
  endtask

  // Full command: called in an IDLE cycle, returns in the result_valid cycle
  task automatic runOp(input logic [4:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] e,
                       input logic [CW-1:0] ex, input logic [W-1:0] disp);
    logic [W-1:0] words[5];
    words = '{a, b, c, d, e};
    checkEq("ready_before", start_ready, 1);
    driveCmd(mask, a, b, c, d, e, ex, disp);
    expQ.push_back(disp);
    step();
    // inputs change after accept; start_valid stays high while busy
    load_mask   = 5'($urandom_range(0, 31));
    v1_val      = 16'($urandom_range(0, 65535));
    v2_val      = 16'($urandom_range(0, 65535));
    r_val       = 16'($urandom_range(0, 65535));
    ir1_val     = 16'($urandom_range(0, 65535));
    ir2_val     = 16'($urandom_range(0, 65535));
    exec_cycles = 8'($urandom_range(0, 255));
    for (int k = 0; k < 5; k++) begin
      if (mask[k]) begin
        checkEq("load_strobe", strobeVec, 32'(1 << k));
        checkEq("load_value", value, words[k]);
        checkEq("load_ready", start_ready, 0);
        step();
      end
    end
    for (int i = 0; i <= int'(ex); i++) begin
      checkEq("exec_state", stateDbg, 2);
      checkEq("exec_strobe", strobeVec, 0);
      checkEq("exec_value", value, 0);
      checkEq("exec_rv", result_valid, 0);
      step();
    end
    checkEq("capture_state", stateDbg, 3);
    checkEq("capture_busy", busy, 1);
    checkEq("capture_strobe", strobeVec, 0);
    step();
    start_valid = 1'b0;
    checkEq("rv_pulse", result_valid, 1);
    checkEq("rv_result", result, expQ.pop_front());
    checkEq("rv_ready", start_ready, 1);
    lastResult = disp;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0;
    load_mask = '0; v1_val = '0; v2_val = '0; r_val = '0; ir1_val = '0; ir2_val = '0;
    exec_cycles = '0; display_in = '0; lastResult = '0;
    step();
    step();
    checkEq("rst_state", stateDbg, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_ready", start_ready, 1);
    checkEq("rst_result", result, 0);
    checkEq("rst_rv", result_valid, 0);
    checkEq("rst_strobe", strobeVec, 0);
    checkEq("rst_value", value, 0);
    rst = 1'b0;
    step();

    // all five registers, exec 4
    runOp(5'b11111, 16'd6, 16'd0, 16'd1, 16'h2000, 16'h0022, 8'd4, 16'h0007);
    step();
    checkEq("rv_clear", result_valid, 0);
    checkEq("result_hold", result, 16'h0007);

    // IR2 only, then back-to-back commands accepted in each result_valid cycle
    runOp(5'b10000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0422, 8'd0, 16'h0002);
    runOp(5'b00000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'd0, 16'h1234);
    runOp(5'b01010, 16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 8'd2, 16'hBEEF);
    step();
    checkEq("b2b_rv_clear", result_valid, 0);
    checkEq("b2b_idle", stateDbg, 0);

    // abort during LOAD: ldR seen in T3, nothing afterwards
    driveCmd(5'b11111, 16'd6, 16'd0, 16'd1, 16'h2000, 16'h0022, 8'd4, 16'h0007);
    step();
    start_valid = 1'b0;
    step();
    step();
    checkEq("abort_ldR", strobeVec, 5'b00100);
    checkEq("abort_value", value, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkEq("abort_idle", stateDbg, 0);
    for (int i = 0; i < 8; i++) begin
      checkEq("abort_no_strobe", strobeVec, 0);
      checkEq("abort_no_rv", result_valid, 0);
      step();
    end
    checkEq("abort_result_hold", result, lastResult);

    // abort during EXEC
    driveCmd(5'b00001, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 8'd5, 16'h7777);
    step();
    start_valid = 1'b0;
    checkEq("abx_ldV1", strobeVec, 5'b00001);
    step();
    checkEq("abx_exec", stateDbg, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkEq("abx_idle", stateDbg, 0);
    for (int i = 0; i < 8; i++) begin
      checkEq("abx_no_rv", result_valid, 0);
      step();
    end
    checkEq("abx_result_hold", result, lastResult);

    // reset at T7 during EXEC, start_valid held high T2..T6 ignored
    driveCmd(5'b11111, 16'd6, 16'd0, 16'd1, 16'h2000, 16'h0022, 8'd4, 16'h0007);
    step();
    start_valid = 1'b0;
    step();
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start_valid = 1'b0;
    checkEq("rstx_exec", stateDbg, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkEq("rstx_idle", stateDbg, 0);
    checkEq("rstx_result", result, 0);
    checkEq("rstx_rv", result_valid, 0);
    checkEq("rstx_strobe", strobeVec, 0);
    checkEq("rstx_value", value, 0);
    step();
    checkEq("rstx_stay_idle", busy, 0);

    // normal command after the mid-operation reset
    runOp(5'b00100, 16'h0, 16'h0, 16'h00F0, 16'h0, 16'h0, 8'd1, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
